rd_fwft_stage: RTL and testbench

- Read-side output stage placed directly downstream of the FIFO read controller, in the rclk domain.
- Consumes the controller's empty flag and the dual-port memory's registered read data; drives the controller's rinc.
- Presents a first-word-fall-through valid/ready stream to the read-domain consumer.
- Hides the 1-cycle memory read latency with a 2-entry output buffer, sustaining one word per cycle.

---
 rtl/rd_fwft_stage_pkg.sv | 22 ++
 rtl/rd_skid_buf.sv | 95 +++++++++
 rtl/rd_fwft_stage.sv | 62 ++++++
 tb/tb_rd_fwft_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rd_fwft_stage_pkg.sv
// Shared definitions for the read-side FWFT output stage.
// Occupancy states of the 2-entry output buffer and the rinc issue rule.
package rd_fwft_stage_pkg;

  // Buffered word count, one state per occupancy level.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } occ_e;

  localparam logic [1:0] OccMax = 2'd2;

  // A new read may be issued while buffered plus in-flight words stay within
  // two, or exactly two when a word leaves the buffer this same cycle.
  function automatic logic issue_ok(logic [1:0] occ, logic infl, logic pop);
    logic [2:0] sum;
    sum = {1'b0, occ} + {2'b00, infl};
    return (sum <= 3'd1) || ((sum == {1'b0, OccMax}) && pop);
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry output buffer: head register drives the stream, skid register
// holds the second word. Occupancy is kept as a small FSM (S0/S1/S2).
module rd_skid_buf
  import rd_fwft_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            count
);

  occ_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, skid_q;
  logic                  pop;
  logic                  load_head, head_from_skid, load_skid;

  assign pop = out_valid & out_ready;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy and data-path steering from arrival and pop.
  always_comb begin
    state_d        = state_q;
    load_head      = 1'b0;
    head_from_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      S0: begin
        if (in_valid) begin
          state_d   = S1;
          load_head = 1'b1;
        end
      end
      S1: begin
        if (in_valid && !pop) begin
          state_d   = S2;
          load_skid = 1'b1;
        end else if (!in_valid && pop) begin
          state_d = S0;
        end else if (in_valid && pop) begin
          load_head = 1'b1;
        end
      end
      S2: begin
        // Arrival without a pop is excluded upstream by the issue rule.
        if (pop) begin
          load_head      = 1'b1;
          head_from_skid = 1'b1;
          if (in_valid) begin
            load_skid = 1'b1;
          end else begin
            state_d = S1;
          end
        end
      end
      default: state_d = S0;
    endcase
  end

  // Stream outputs derived from registered state only.
  always_comb begin
    out_valid = (state_q != S0);
    out_data  = head_q;
    count     = state_q;
  end

  // Head and skid data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_head) begin
        head_q <= head_from_skid ? skid_q : in_data;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/rd_fwft_stage.sv
// Read-side FWFT output stage, rclk domain. Issues rinc to the read
// controller, tracks the 1-cycle memory latency and feeds the skid buffer.
// Optional macro RD_FWFT_LEVEL_EN adds a 'level' output reporting occupancy.
module rd_fwft_stage
  import rd_fwft_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  empty,
  output logic                  rinc,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
`ifdef RD_FWFT_LEVEL_EN
  output logic [1:0]            level,
`endif
  output logic [DATA_WIDTH-1:0] m_data
);

  logic       infl_q;
  logic [1:0] occ;
  logic       pop;

  assign pop = m_valid & m_ready;

  // rinc is gated by reset so nothing is popped while the stage is held.
  always_comb begin
    rinc = rrst_n & ~empty & issue_ok(occ, infl_q, pop);
  end

  // In-flight flag: read data lands one cycle after the rinc cycle.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      infl_q <= 1'b0;
    end else begin
      infl_q <= rinc;
    end
  end

  rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .in_valid  (infl_q),
    .in_data   (rdata),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (m_data),
    .count     (occ)
  );

`ifdef RD_FWFT_LEVEL_EN
  // Occupancy straight from the buffer's state register.
  always_comb begin
    level = occ;
  end
`endif

endmodule

// File: tb/tb_rd_fwft_stage.sv
// Directed bench for rd_fwft_stage with a small FIFO/memory model and an
// in-order scoreboard sampled on the falling edge.
module tb_rd_fwft_stage;

  localparam int unsigned DW = 32;

  logic          rclk;
  logic          rrst_n;
  logic          empty;
  logic          rinc;
  logic [DW-1:0] rdata;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
`ifdef RD_FWFT_LEVEL_EN
  logic [1:0]    level;
`endif

  logic [DW-1:0] mem [0:2047];
  int            rd_idx;
  int            n_avail;
  logic          force_empty;

  int            total;
  int            bad;
  int            exp_idx;
  logic          prev_hold;
  logic [DW-1:0] prev_data;

  logic          s_rinc, s_valid;
  logic [DW-1:0] s_data;
  logic [1:0]    s_occ;

  rd_fwft_stage #(
    .DATA_WIDTH (DW)
  ) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .empty   (empty),
    .rinc    (rinc),
    .rdata   (rdata),
    .m_valid (m_valid),
    .m_ready (m_ready),
`ifdef RD_FWFT_LEVEL_EN
    .level   (level),
`endif
    .m_data  (m_data)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  assign empty = force_empty | (rd_idx >= n_avail);

  // Memory/controller model: registered read, pointer advances on rinc.
  always @(posedge rclk) begin
    if (rinc) begin
      rdata  <= mem[rd_idx];
      rd_idx <= rd_idx + 1;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Sample at the falling edge, run invariants and scoreboard, then return
  // just after the next rising edge so the caller can drive inputs.
  task automatic cyc();
    @(negedge rclk);
    s_rinc  = rinc;
    s_valid = m_valid;
    s_data  = m_data;
    s_occ   = dut.occ;
    check("occ_le_2", {31'b0, (dut.occ <= 2'd2)}, 32'd1);
    check("no_rinc_when_empty", {31'b0, (rinc & empty)}, 32'd0);
    if (!rrst_n) begin
      exp_idx   = rd_idx;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && m_valid) check("hold_stable", m_data, prev_data);
      if (m_valid && m_ready) begin
        check("sb_order", m_data, mem[exp_idx]);
        exp_idx++;
      end
      prev_hold = m_valid & ~m_ready;
      prev_data = m_data;
    end
    @(posedge rclk);
    #1;
  endtask

  initial begin
    int base;
    int rcount;
    int guard;
    int target;
    total       = 0;
    bad         = 0;
    exp_idx     = 0;
    rd_idx      = 0;
    prev_hold   = 1'b0;
    prev_data   = '0;
    rdata       = '0;
    rrst_n      = 1'b0;
    force_empty = 1'b0;
    m_ready     = 1'b0;
    mem[0]      = 32'hA5A5_0001;
    n_avail     = 1;

    // Reset held with a non-empty FIFO.
    cyc();
    check("rst_rinc", {31'b0, s_rinc}, 32'd0);
    check("rst_valid", {31'b0, s_valid}, 32'd0);
    check("rst_data", s_data, 32'd0);
    force_empty = 1'b1;
    rrst_n      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("idle_rinc", {31'b0, s_rinc}, 32'd0);
    end

    // Single word: rinc in cycle 0, m_valid in cycle 2 only.
    force_empty = 1'b0;
    m_ready     = 1'b1;
    cyc();
    check("single_rinc_c0", {31'b0, s_rinc}, 32'd1);
    check("single_valid_c0", {31'b0, s_valid}, 32'd0);
    cyc();
    check("single_rinc_c1", {31'b0, s_rinc}, 32'd0);
    check("single_valid_c1", {31'b0, s_valid}, 32'd0);
    cyc();
    check("single_valid_c2", {31'b0, s_valid}, 32'd1);
    check("single_data_c2", s_data, 32'hA5A5_0001);
    cyc();
    check("single_valid_c3", {31'b0, s_valid}, 32'd0);

    // Streaming 16 words with no gaps.
    base = n_avail;
    for (int i = 0; i < 16; i++) mem[base+i] = i;
    n_avail = base + 16;
    cyc();
    check("stream_rinc_c0", {31'b0, s_rinc}, 32'd1);
    cyc();
    check("stream_valid_c1", {31'b0, s_valid}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      cyc();
      check("stream_valid", {31'b0, s_valid}, 32'd1);
      check("stream_data", s_data, i);
    end
    cyc();
    check("stream_valid_end", {31'b0, s_valid}, 32'd0);

    // Backpressure: 10 stalled cycles then drain 8 words.
    base = n_avail;
    for (int i = 0; i < 8; i++) mem[base+i] = 32'h100 + i;
    m_ready = 1'b0;
    n_avail = base + 8;
    rcount  = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      rcount += int'(s_rinc);
    end
    check("bp_rinc_count", rcount, 32'd2);
    check("bp_occ", {30'b0, s_occ}, 32'd2);
    check("bp_head", s_data, 32'h100);
    m_ready = 1'b1;
    guard   = 0;
    while (exp_idx != base + 8 && guard < 40) begin
      cyc();
      guard++;
    end
    check("bp_drained", exp_idx, base + 8);
    cyc();
    check("bp_valid_end", {31'b0, s_valid}, 32'd0);

    // Random ready and random supply over 1000 words.
    target = n_avail + 1000;
    for (int i = n_avail; i < target; i++) mem[i] = $urandom;
    guard = 0;
    while (exp_idx != target && guard < 20000) begin
      m_ready = 1'($urandom_range(0, 1));
      if (n_avail < target && $urandom_range(0, 2) != 0) n_avail++;
      cyc();
      guard++;
    end
    check("rand_all_delivered", exp_idx, target);

    // Reset mid-stream during steady-state streaming.
    base = n_avail;
    for (int i = 0; i < 8; i++) mem[base+i] = 32'hBEEF_0000 + i;
    m_ready = 1'b1;
    n_avail = base + 8;
    for (int i = 0; i < 4; i++) cyc();
    #2;
    rrst_n = 1'b0;
    #1;
    check("midrst_valid_async", {31'b0, m_valid}, 32'd0);
    check("midrst_rinc", {31'b0, rinc}, 32'd0);
    n_avail = rd_idx;
    cyc();
    rrst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("midrst_no_stale", {31'b0, s_valid}, 32'd0);
    end
    mem[n_avail] = 32'h0000_600D;
    n_avail++;
    cyc();
    cyc();
    cyc();
    check("post_rst_valid", {31'b0, s_valid}, 32'd1);
    check("post_rst_data", s_data, 32'h0000_600D);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
